// File: rtl/hazard_stall_unit_if.sv
// Hazard-unit bundle: pipeline status into the hazard controller, PC/pipeline-register control back out.
// The master modport is the pipeline side and the slave modport is the hazard unit.
interface hazard_stall_unit_if;
    logic [4:0] IFID_rs_i;
    logic [4:0] IFID_rt_i;
    logic [4:0] IDEX_rt_i;
    logic       IDEX_MemRead_i;
    logic       branch_taken_i;
    logic       imem_ready_i;
    logic       dmem_req_i;
    logic       dmem_ready_i;
    logic       PC_Write_o;
    logic       IFID_Write_o;
    logic       IFID_Flush_o;
    logic       IDEX_Flush_o;
    logic       EXMEM_Flush_o;
    logic       pipe_hold_o;
    logic       timeout_o;
    logic [1:0] state_o;

    modport master (
        output IFID_rs_i, IFID_rt_i, IDEX_rt_i, IDEX_MemRead_i, branch_taken_i,
               imem_ready_i, dmem_req_i, dmem_ready_i,
        input  PC_Write_o, IFID_Write_o, IFID_Flush_o, IDEX_Flush_o, EXMEM_Flush_o,
               pipe_hold_o, timeout_o, state_o
    );

    modport slave (
        input  IFID_rs_i, IFID_rt_i, IDEX_rt_i, IDEX_MemRead_i, branch_taken_i,
               imem_ready_i, dmem_req_i, dmem_ready_i,
        output PC_Write_o, IFID_Write_o, IFID_Flush_o, IDEX_Flush_o, EXMEM_Flush_o,
               pipe_hold_o, timeout_o, state_o
    );
endinterface

// File: rtl/hazard_stall_unit.sv
// MIPS 5-stage hazard controller: load-use stalls, branch flushes, imem/dmem wait freezes; HAZARD_PERF_CNT_EN adds stall_cnt_o.
// Control outputs are combinational (same cycle); state, counters and timeout are registered. Stalls themselves are the backpressure.
module hazard_stall_unit #(
    parameter int FLUSH_EXTRA  = 0,
    parameter int WAIT_TIMEOUT = 255
) (
    input  logic               clk_i,
    input  logic               rst_i,
    hazard_stall_unit_if.slave hz
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0]        stall_cnt_o
`endif
);
    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FLUSH = 2'd1,
        IWAIT = 2'd2,
        DWAIT = 2'd3
    } state_t;

    localparam logic [15:0] WT = 16'(WAIT_TIMEOUT);
    localparam logic [3:0]  FX = 4'(FLUSH_EXTRA);

    state_t      state, state_nxt;
    logic [3:0]  flush_cnt, flush_cnt_nxt;
    logic [15:0] wait_cnt;
    logic [16:0] wait_cnt_inc;
    logic        timeout;
    logic        in_wait;
    logic        lu, dmiss;
    logic        freeze, rules;
    logic        pc_write, ifid_write, ifid_flush, idex_flush, exmem_flush, hold;

    assign lu = hz.IDEX_MemRead_i && (hz.IDEX_rt_i != 5'd0) &&
                ((hz.IDEX_rt_i == hz.IFID_rs_i) || (hz.IDEX_rt_i == hz.IFID_rt_i));
    assign dmiss        = hz.dmem_req_i && !hz.dmem_ready_i;
    assign in_wait      = (state == IWAIT) || (state == DWAIT);
    assign wait_cnt_inc = {1'b0, wait_cnt} + 17'd1;

    always_comb begin
        pc_write      = 1'b1;
        ifid_write    = 1'b1;
        ifid_flush    = 1'b0;
        idex_flush    = 1'b0;
        exmem_flush   = 1'b0;
        hold          = 1'b0;
        state_nxt     = RUN;
        flush_cnt_nxt = flush_cnt;
        freeze        = 1'b0;
        rules         = 1'b0;

        case (state)
            DWAIT: begin
                if (!hz.dmem_ready_i) freeze = 1'b1;
                else                  rules  = 1'b1;
            end
            FLUSH: begin
                if (dmiss) begin
                    freeze = 1'b1;
                end else begin
                    ifid_flush    = 1'b1;
                    flush_cnt_nxt = flush_cnt - 4'd1;
                    state_nxt     = (flush_cnt <= 4'd1) ? RUN : FLUSH;
                end
            end
            default: begin
                if (dmiss) freeze = 1'b1;
                else       rules  = 1'b1;
            end
        endcase

        if (freeze) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            hold       = 1'b1;
            state_nxt  = DWAIT;
        end

        // Branch beats imem wait beats load-use; a taken branch always reloads the PC.
        if (rules) begin
            if (hz.branch_taken_i) begin
                ifid_flush    = 1'b1;
                idex_flush    = 1'b1;
                exmem_flush   = 1'b1;
                flush_cnt_nxt = FX;
                state_nxt     = (FX != 4'd0) ? FLUSH : RUN;
            end else if (!hz.imem_ready_i) begin
                pc_write   = 1'b0;
                ifid_flush = 1'b1;
                state_nxt  = IWAIT;
            end else if (lu) begin
                pc_write   = 1'b0;
                ifid_write = 1'b0;
                idex_flush = 1'b1;
                state_nxt  = RUN;
            end
        end

        if (!rst_i) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            ifid_flush  = 1'b0;
            idex_flush  = 1'b0;
            exmem_flush = 1'b0;
            hold        = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state     <= RUN;
            flush_cnt <= 4'd0;
            wait_cnt  <= 16'd0;
            timeout   <= 1'b0;
        end else begin
            state     <= state_nxt;
            flush_cnt <= flush_cnt_nxt;
            if (in_wait && (wait_cnt_inc >= {1'b0, WT}))
                timeout <= 1'b1;
            // Saturates at the threshold so the sticky flag never depends on wrap.
            if ((state_nxt == RUN) || (state_nxt == FLUSH))
                wait_cnt <= 16'd0;
            else if (in_wait && (wait_cnt != WT))
                wait_cnt <= wait_cnt_inc[15:0];
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i)
            stall_cnt_o <= 32'd0;
        else if (!pc_write)
            stall_cnt_o <= stall_cnt_o + 32'd1;
    end
`endif

    assign hz.PC_Write_o    = pc_write;
    assign hz.IFID_Write_o  = ifid_write;
    assign hz.IFID_Flush_o  = ifid_flush;
    assign hz.IDEX_Flush_o  = idex_flush;
    assign hz.EXMEM_Flush_o = exmem_flush;
    assign hz.pipe_hold_o   = hold;
    assign hz.timeout_o     = timeout;
    assign hz.state_o       = state;
endmodule
